// File: rtl/ram_bist_master.sv
// March-free BIST initiator: writes seed+addr to every word, idles, reads back
// and reports pass, saturating mismatch count and first failing address.
`timescale 1ns/1ps
module ram_bist_master #(
    parameter int DEPTH   = 32,
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = 4,
    parameter int ERR_W   = 16
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [WIDTH-1:0]  i_seed,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]  i_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ERR_W-1:0]  o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYC - 1);

    state_t              r_state, w_state;
    logic [WIDTH-1:0]    r_seed, w_seed;
    logic                r_wr, w_wr;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr;
    logic [WIDTH-1:0]    r_wr_data, w_wr_data;
    logic                r_rd, w_rd;
    logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr;
    logic [31:0]         r_gap, w_gap;
    logic                r_abt, w_abt;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_pass, w_pass;
    logic [ERR_W-1:0]    r_err, w_err;
    logic [ADDR_W-1:0]   r_first, w_first;

    // Tail stage lines up with i_rd_data for the read issued RD_LAT+1 edges ago
    logic [RD_LAT:0]     r_pv;
    logic [ADDR_W-1:0]   r_pa [RD_LAT+1];

    logic                w_abort;
    logic                w_empty;
    logic                w_mis;

    assign w_abort = i_abort && (r_state inside {S_WRITE, S_GAP, S_READ, S_DRAIN});
    assign w_empty = (r_pv == '0);
    assign w_mis   = r_pv[RD_LAT] && (i_rd_data != r_seed + WIDTH'(r_pa[RD_LAT]));

    always_comb begin
        w_state   = r_state;
        w_seed    = r_seed;
        w_wr      = r_wr;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_rd      = r_rd;
        w_rd_addr = r_rd_addr;
        w_gap     = r_gap;
        w_abt     = r_abt;
        w_done    = 1'b0;
        w_pass    = r_pass;
        w_err     = r_err;
        w_first   = r_first;
        if (w_abort) begin
            w_state   = S_DONE;
            w_wr      = 1'b0;
            w_wr_addr = '0;
            w_wr_data = '0;
            w_rd      = 1'b0;
            w_rd_addr = '0;
            w_abt     = 1'b1;
        end else begin
            if (w_mis) begin
                if (r_err != '1) w_err = r_err + 1'b1;
                if (r_err == '0) w_first = r_pa[RD_LAT];
            end
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state   = S_WRITE;
                        w_seed    = i_seed;
                        w_wr      = 1'b1;
                        w_wr_addr = '0;
                        w_wr_data = i_seed;
                        w_pass    = 1'b0;
                        w_err     = '0;
                        w_first   = '0;
                        w_abt     = 1'b0;
                    end
                end
                S_WRITE: begin
                    if (r_wr_addr == LAST_ADDR) begin
                        w_wr      = 1'b0;
                        w_wr_addr = '0;
                        w_wr_data = '0;
                        w_gap     = '0;
                        if (GAP_CYC == 0) begin
                            w_state   = S_READ;
                            w_rd      = 1'b1;
                            w_rd_addr = '0;
                        end else begin
                            w_state = S_GAP;
                        end
                    end else begin
                        w_wr_addr = r_wr_addr + 1'b1;
                        w_wr_data = r_wr_data + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        w_state   = S_READ;
                        w_rd      = 1'b1;
                        w_rd_addr = '0;
                    end else begin
                        w_gap = r_gap + 1'b1;
                    end
                end
                S_READ: begin
                    if (r_rd_addr == LAST_ADDR) begin
                        w_state   = S_DRAIN;
                        w_rd      = 1'b0;
                        w_rd_addr = '0;
                    end else begin
                        w_rd_addr = r_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) w_state = S_DONE;
                end
                S_DONE: begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_pass  = !r_abt && (r_err == '0);
                end
                default: w_state = S_IDLE;
            endcase
        end
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_seed    <= '0;
            r_wr      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd      <= 1'b0;
            r_rd_addr <= '0;
            r_gap     <= '0;
            r_abt     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
            r_first   <= '0;
        end else begin
            r_state   <= w_state;
            r_seed    <= w_seed;
            r_wr      <= w_wr;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_rd      <= w_rd;
            r_rd_addr <= w_rd_addr;
            r_gap     <= w_gap;
            r_abt     <= w_abt;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_pass    <= w_pass;
            r_err     <= w_err;
            r_first   <= w_first;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst || w_abort) begin
            r_pv <= '0;
            for (int k = 0; k <= RD_LAT; k++) r_pa[k] <= '0;
        end else begin
            r_pv[0] <= r_rd;
            r_pa[0] <= r_rd_addr;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pa[k] <= r_pa[k-1];
            end
        end
    end

    assign o_wr             = r_wr;
    assign o_wr_addr        = r_wr_addr;
    assign o_wr_data        = r_wr_data;
    assign o_rd             = r_rd;
    assign o_rd_addr        = r_rd_addr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_cnt        = r_err;
    assign o_first_err_addr = r_first;

endmodule

// File: tb/tb_ram_bist_master.sv
// Scoreboard bench for ram_bist_master: queued expected writes/reads/results,
// a negedge monitor, and a RAM model that can corrupt chosen addresses.
`timescale 1ns/1ps
module tb_ram_bist_master;

    localparam int DEPTH   = 32;
    localparam int WIDTH   = 32;
    localparam int ADDR_W  = 32;
    localparam int RD_LAT  = 1;
    localparam int GAP_CYC = 4;
    localparam int ERR_W   = 16;
    localparam int AW      = $clog2(DEPTH);

    logic              clk;
    logic              i_rst;
    logic              i_start;
    logic              i_abort;
    logic [WIDTH-1:0]  i_seed;
    logic              o_wr;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [WIDTH-1:0]  o_wr_data;
    logic              o_rd;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [WIDTH-1:0]  i_rd_data;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic [ERR_W-1:0]  o_err_cnt;
    logic [ADDR_W-1:0] o_first_err_addr;

    ram_bist_master #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC), .ERR_W(ERR_W)
    ) dut (
        .i_sys_clk        (clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_seed           (i_seed),
        .o_wr             (o_wr),
        .o_wr_addr        (o_wr_addr),
        .o_wr_data        (o_wr_data),
        .o_rd             (o_rd),
        .o_rd_addr        (o_rd_addr),
        .i_rd_data        (i_rd_data),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_pass           (o_pass),
        .o_err_cnt        (o_err_cnt),
        .o_first_err_addr (o_first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data for a read sampled at edge E is presented after edge E+RD_LAT
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rp  [RD_LAT+1];
    logic [DEPTH-1:0] corrupt;

    always @(posedge clk) begin
        if (i_rst) begin
            for (int k = 0; k <= RD_LAT; k++) rp[k] <= '0;
        end else begin
            if (o_wr) mem[o_wr_addr[AW-1:0]] <= o_wr_data;
            if (o_rd)
                rp[0] <= mem[o_rd_addr[AW-1:0]] ^
                         (corrupt[o_rd_addr[AW-1:0]] ? 32'h5A00_0001 : 32'h0);
            else
                rp[0] <= '0;
            for (int k = 1; k <= RD_LAT; k++) rp[k] <= rp[k-1];
        end
    end
    assign i_rd_data = rp[RD_LAT];

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
    } wexp_t;

    typedef struct packed {
        logic              pass;
        logic [ERR_W-1:0]  err;
        logic [ADDR_W-1:0] first;
    } res_t;

    wexp_t             wq [$];
    logic [ADDR_W-1:0] rq [$];
    res_t              resq [$];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    wexp_t             mw;
    logic [ADDR_W-1:0] ma;
    res_t              mr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_wr) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'(o_wr), 64'd0);
                end else begin
                    mw = wq.pop_front();
                    chk("wr_addr", 64'(o_wr_addr), 64'(mw.a));
                    chk("wr_data", 64'(o_wr_data), 64'(mw.d));
                end
            end
            if (o_rd) begin
                rd_cnt++;
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 64'(o_rd), 64'd0);
                end else begin
                    ma = rq.pop_front();
                    chk("rd_addr", 64'(o_rd_addr), 64'(ma));
                end
            end
            if (o_done) begin
                if (resq.size() == 0) begin
                    chk("done_unexpected", 64'(o_done), 64'd0);
                end else begin
                    mr = resq.pop_front();
                    chk("pass", 64'(o_pass), 64'(mr.pass));
                    chk("err_cnt", 64'(o_err_cnt), 64'(mr.err));
                    chk("first_err", 64'(o_first_err_addr), 64'(mr.first));
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk(nm, 64'({o_wr, o_rd, o_busy, o_done, o_pass}), 64'd0);
        chk({nm, "_addr"}, 64'(o_wr_addr | o_rd_addr | o_first_err_addr), 64'd0);
        chk({nm, "_data"}, 64'(o_wr_data) | 64'(o_err_cnt), 64'd0);
    endtask

    task automatic run(input logic [WIDTH-1:0] seed, input logic [DEPTH-1:0] mask,
                       input int abort_at, input bit spam);
        int   nrd;
        int   errs;
        int   first;
        bit   found;
        res_t r;
        corrupt = mask;
        for (int a = 0; a < DEPTH; a++)
            wq.push_back({ADDR_W'(a), seed + WIDTH'(a)});
        nrd = (abort_at >= 0) ? abort_at + 1 : DEPTH;
        for (int a = 0; a < nrd; a++) rq.push_back(ADDR_W'(a));
        errs  = 0;
        first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (mask[a]) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
        if (abort_at >= 0) begin
            r.pass  = 1'b0;
            r.err   = '0;
            r.first = '0;
        end else begin
            r.pass  = (errs == 0);
            r.err   = ERR_W'(errs);
            r.first = ADDR_W'(first);
        end
        resq.push_back(r);
        wr_cnt = 0;
        rd_cnt = 0;
        @(posedge clk) #1;
        i_start = 1'b1;
        i_seed  = seed;
        @(posedge clk) #1;
        i_start = 1'b0;
        i_seed  = $urandom;
        chk("busy_after_start", 64'(o_busy), 64'd1);
        if (spam) begin
            for (int i = 0; i < 40; i++) begin
                i_start = 1'($urandom);
                i_seed  = $urandom;
                @(posedge clk) #1;
            end
            i_start = 1'b0;
        end
        if (abort_at >= 0) begin
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
                if (o_rd && o_rd_addr == ADDR_W'(abort_at)) found = 1'b1;
                else @(posedge clk) #1;
            end
            chk("abort_reached", 64'(found), 64'd1);
            i_abort = 1'b1;
            @(posedge clk) #1;
            i_abort = 1'b0;
            chk("abort_rd_low", 64'(o_rd), 64'd0);
            chk("abort_done_early", 64'(o_done), 64'd0);
            @(posedge clk) #1;
            chk("abort_done", 64'(o_done), 64'd1);
        end
        for (int i = 0; i < 300 && resq.size() != 0; i++) @(posedge clk) #1;
        chk("done_seen", 64'(resq.size()), 64'd0);
        chk("wr_cycles", 64'(wr_cnt), 64'(DEPTH));
        chk("rd_cycles", 64'(rd_cnt), 64'(nrd));
        chk("wq_left", 64'(wq.size()), 64'd0);
        chk("rq_left", 64'(rq.size()), 64'd0);
        repeat (3) @(posedge clk) #1;
        chk("busy_idle", 64'(o_busy), 64'd0);
        chk("hold_err", 64'(o_err_cnt), 64'(r.err));
        chk("hold_pass", 64'(o_pass), 64'(r.pass));
        wq.delete();
        rq.delete();
        resq.delete();
    endtask

    initial begin
        bit found;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_seed  = '0;
        corrupt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        i_rst = 1'b0;

        run(32'h0, '0, -1, 1'b0);
        run(32'hFFFF_FFF0, '0, -1, 1'b0);
        run($urandom, DEPTH'((1 << 5) | (1 << 9)), -1, 1'b0);
        run($urandom, '0, 10, 1'b0);
        run($urandom, '0, -1, 1'b1);

        // Reset in the middle of the write sweep
        corrupt = '0;
        for (int a = 0; a < DEPTH; a++) wq.push_back({ADDR_W'(a), WIDTH'(a) + 32'h100});
        @(posedge clk) #1;
        i_start = 1'b1;
        i_seed  = 32'h100;
        @(posedge clk) #1;
        i_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (o_wr && o_wr_addr == 7) found = 1'b1;
            else @(posedge clk) #1;
        end
        chk("rst_point_reached", 64'(found), 64'd1);
        i_rst = 1'b1;
        @(posedge clk) #1;
        chk_all_zero("mid_reset");
        wq.delete();
        rq.delete();
        resq.delete();
        i_rst = 1'b0;

        run($urandom, '0, -1, 1'b0);
        for (int t = 0; t < 3; t++)
            run($urandom, DEPTH'($urandom & $urandom & $urandom), -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
